compare_stream: RTL and testbench
=================================

Name: compare_stream

Overview:
- Parametrised successor to the two-input min comparator used in the distance search.
- Consumes a stream of (distance, index) candidates framed by startsig and in_last, and tracks the running minimum and its index.
- Publishes the frame result with a one-cycle out_valid pulse.
- Sits between the per-candidate distance datapath and the disparity/eye-position selection logic.
- Replaces pairwise compare trees with a single sequential unit that handles any frame length.

Parameters:
- DW, 18, data (distance) width in bits
- IW, 6, candidate index width in bits
- CW, 7, accepted-sample counter width in bits

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  synchronous, active-high reset
- startsig  input  1  single-cycle pulse; opens a new frame
- in_valid  input  1  candidate present this cycle
- in_data  input  DW  candidate distance, unsigned
- in_idx  input  IW  candidate index
- in_last  input  1  qualifies in_valid; marks the final candidate of the frame
- out  output  DW  frame minimum distance
- outp  output  IW  index of the frame minimum
- out_valid  output  1  one-cycle pulse; out/outp hold a new result
- busy  output  1  high while a frame is open (RUN state)
- count  output  CW  candidates accepted in the current or last frame

Behaviour:
- Interface: one clock (clk); reset rst is synchronous and active-high. All state updates on rising clk; no combinational input-to-output paths.
- Reset: state=IDLE; out=0, outp=0, out_valid=0, busy=0, count=0; internal best=all-ones, bestp=0.
- States are IDLE, RUN and DONE.
- IDLE:
  - in_valid is ignored.
  - startsig -> RUN; best=all-ones, bestp=0, count=0.
- RUN:
  - busy=1.
  - When in_valid=1, the candidate is compared unsigned against best. If in_data < best (strict), then best=in_data and bestp=in_idx.
  - Ties keep the earlier candidate.
  - count increments per accepted candidate and saturates at 2^CW-1.
  - in_valid=1 with in_last=1: the candidate is included in the comparison. Then out/outp load the final min (including this candidate) and state -> DONE.
  - in_last with in_valid=0 is ignored.
  - startsig in RUN restarts the frame: best, bestp and count are cleared, and any in_valid in that same cycle is dropped. out/outp are untouched.
- DONE: lasts exactly one cycle.
  - out_valid=1, busy=0.
  - Next state is RUN if startsig=1 this cycle (with the same clearing as IDLE->RUN); otherwise IDLE.
  - in_valid in DONE is ignored.
- Latency: out_valid asserts in the cycle after the in_valid&in_last cycle.
- out/outp change only on entry to DONE and otherwise hold indefinitely, across restarts and IDLE periods.
- count holds its final value until the next frame starts.
- Boundaries:
  - 1-sample frame: out=that sample.
  - A candidate equal to all-ones never replaces the initial best. If every candidate is all-ones, out=all-ones and outp=0.
  - Back-to-back frames are supported: a new frame may start in the DONE cycle.
  - Reset mid-frame aborts the frame with no out_valid.

Optional Feature:
- Macro: COMPARE_STREAM_SECOND_EN.
- When defined, the block adds output ports out2 [DW] and outp2 [IW], tracking the second-smallest distance and its index for match-ambiguity checks.
- Per accepted candidate:
  - If in_data < best: second=best, secondp=bestp, then best=in_data, bestp=in_idx.
  - Else if in_data < second: second=in_data, secondp=in_idx.
- second is initialised to all-ones and secondp to 0 at frame start. A 1-sample frame therefore reports out2=all-ones, outp2=0.
- out2/outp2 load together with out/outp and reset to 0.
- When undefined, these ports and their registers do not exist, and the rest of the behaviour is identical.

Test Plan:
- Basic min: rst; startsig; stream (100,0),(40,1),(75,2),(40,3 last) -> out_valid one cycle after last; out=40, outp=1 (earlier of the tie wins); count=4.
- Restart mid-frame: startsig; (5,0),(9,1); startsig together with valid (1,2); then (30,3),(20,4 last) -> out=20, outp=4, count=2; (1,2) is dropped.
- Back-to-back frames: frame A (7,0 last) with startsig asserted in the DONE cycle, then frame B (3,5),(8,6 last) -> two out_valid pulses; first out=7/outp=0, then out=3/outp=5; out holds 3 afterwards.
- Reset/idle: in_valid pulses while IDLE -> no out_valid, out stays 0. Reset asserted in RUN after (2,1) -> no out_valid, and busy=0 next cycle.
- Saturation and extremes: CW=3; 10-sample frame with all-ones data except (0x3FFFF-1,9 last) -> count=7; out=0x3FFFE, outp=9.
- With COMPARE_STREAM_SECOND_EN defined: (50,0),(20,1),(30,2 last) -> out=20/outp=1, out2=30/outp2=2. Single-sample frame (4,3 last) -> out2=0x3FFFF, outp2=0.

Source files
------------

// File: rtl/compare_stream.sv
// compare_stream: framed streaming unsigned-minimum tracker with index and saturating accept count.
// Define COMPARE_STREAM_SECOND_EN to add second-smallest tracking on out2/outp2.
module compare_stream #(
  parameter int DW = 18,
  parameter int IW = 6,
  parameter int CW = 7
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          startsig,
  input  logic          in_valid,
  input  logic [DW-1:0] in_data,
  input  logic [IW-1:0] in_idx,
  input  logic          in_last,
  output logic [DW-1:0] out,
  output logic [IW-1:0] outp,
`ifdef COMPARE_STREAM_SECOND_EN
  output logic [DW-1:0] out2,
  output logic [IW-1:0] outp2,
`endif
  output logic          out_valid,
  output logic          busy,
  output logic [CW-1:0] count
);
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  state_t        state_q, state_d;
  logic [DW-1:0] best_q, best_d, out_q, out_d;
  logic [IW-1:0] bestp_q, bestp_d, outp_q, outp_d;
  logic [CW-1:0] count_q, count_d;
  logic          take, fin, lt_best;
`ifdef COMPARE_STREAM_SECOND_EN
  logic [DW-1:0] second_q, second_d, out2_q, out2_d;
  logic [IW-1:0] secondp_q, secondp_d, outp2_q, outp2_d;
  logic          lt_second;
`endif
  // a start pulse in any state clears the frame, so it also drops same-cycle samples
  always_comb begin
    take    = state_q == RUN && in_valid && !startsig;
    fin     = take && in_last;
    lt_best = in_data < best_q;
    state_d = startsig ? RUN : state_q == RUN ? (fin ? DONE : RUN) : IDLE;
    best_d  = startsig ? '1 : take && lt_best ? in_data : best_q;
    bestp_d = startsig ? '0 : take && lt_best ? in_idx : bestp_q;
    count_d = startsig ? '0 : take && count_q != '1 ? count_q + 1'b1 : count_q;
    out_d   = fin ? best_d : out_q;
    outp_d  = fin ? bestp_d : outp_q;
  end
`ifdef COMPARE_STREAM_SECOND_EN
  always_comb begin
    lt_second = in_data < second_q;
    second_d  = startsig ? '1 : take && lt_best ? best_q : take && lt_second ? in_data : second_q;
    secondp_d = startsig ? '0 : take && lt_best ? bestp_q : take && lt_second ? in_idx : secondp_q;
    out2_d    = fin ? second_d : out2_q;
    outp2_d   = fin ? secondp_d : outp2_q;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      second_q  <= '1;
      secondp_q <= '0;
      out2_q    <= '0;
      outp2_q   <= '0;
    end else begin
      second_q  <= second_d;
      secondp_q <= secondp_d;
      out2_q    <= out2_d;
      outp2_q   <= outp2_d;
    end
  end
  assign out2  = out2_q;
  assign outp2 = outp2_q;
`endif
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      best_q  <= '1;
      bestp_q <= '0;
      count_q <= '0;
      out_q   <= '0;
      outp_q  <= '0;
    end else begin
      state_q <= state_d;
      best_q  <= best_d;
      bestp_q <= bestp_d;
      count_q <= count_d;
      out_q   <= out_d;
      outp_q  <= outp_d;
    end
  end
  assign out       = out_q;
  assign outp      = outp_q;
  assign out_valid = state_q == DONE;
  assign busy      = state_q == RUN;
  assign count     = count_q;
endmodule

// File: tb/tb_compare_stream.sv
// tb_compare_stream: queue-based frame model checked every cycle, plus directed literal checks.
module tb_compare_stream;
  localparam int DW = 18;
  localparam int IW = 6;
  localparam logic [DW-1:0] ONES = '1;
  typedef struct {logic [DW-1:0] d; logic [IW-1:0] i;} cand_t;
  logic clk = 0, rst = 1, startsig = 0, in_valid = 0, in_last = 0;
  logic [DW-1:0] in_data = '0;
  logic [IW-1:0] in_idx = '0;
  logic [DW-1:0] out_a, out_b;
  logic [IW-1:0] outp_a, outp_b;
  logic ov_a, ov_b, busy_a, busy_b;
  logic [6:0] count_a;
  logic [2:0] count_b;
`ifdef COMPARE_STREAM_SECOND_EN
  logic [DW-1:0] out2_a, out2_b;
  logic [IW-1:0] outp2_a, outp2_b;
`endif
  int checks = 0, errors = 0;
  cand_t q[$];
  bit open = 0, done = 0;
  int n = 0;
  logic [DW-1:0] e_out = '0, e_out2 = '0;
  logic [IW-1:0] e_outp = '0, e_outp2 = '0;
  always #5 clk = ~clk;
  compare_stream #(.DW(DW), .IW(IW), .CW(7)) dut_a (
    .clk(clk), .rst(rst), .startsig(startsig), .in_valid(in_valid), .in_data(in_data),
    .in_idx(in_idx), .in_last(in_last), .out(out_a), .outp(outp_a),
`ifdef COMPARE_STREAM_SECOND_EN
    .out2(out2_a), .outp2(outp2_a),
`endif
    .out_valid(ov_a), .busy(busy_a), .count(count_a));
  compare_stream #(.DW(DW), .IW(IW), .CW(3)) dut_b (
    .clk(clk), .rst(rst), .startsig(startsig), .in_valid(in_valid), .in_data(in_data),
    .in_idx(in_idx), .in_last(in_last), .out(out_b), .outp(outp_b),
`ifdef COMPARE_STREAM_SECOND_EN
    .out2(out2_b), .outp2(outp2_b),
`endif
    .out_valid(ov_b), .busy(busy_b), .count(count_b));
  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
    end
  endtask
  // smallest value among frame candidates other than position skip; earliest wins ties
  function automatic void pick(input int skip, output logic [DW-1:0] d, output logic [IW-1:0] i, output int pos);
    logic [DW-1:0] m = ONES;
    foreach (q[k]) if (k != skip && q[k].d < m) m = q[k].d;
    d = m;
    i = '0;
    pos = -1;
    if (m != ONES) foreach (q[k]) if (k != skip && q[k].d == m && pos < 0) begin
      pos = k;
      i = q[k].i;
    end
  endfunction
  initial forever begin
    int p1, p2;
    @(posedge clk);
    if (rst) begin
      open = 0; done = 0; q.delete(); n = 0;
      e_out = '0; e_outp = '0; e_out2 = '0; e_outp2 = '0;
    end else begin
      done = 0;
      if (startsig) begin
        open = 1; q.delete(); n = 0;
      end else if (open && in_valid) begin
        q.push_back('{in_data, in_idx});
        n++;
        if (in_last) begin
          pick(-1, e_out, e_outp, p1);
          pick(p1, e_out2, e_outp2, p2);
          open = 0;
          done = 1;
        end
      end
    end
  end
  initial begin
    @(posedge clk);
    forever begin
      @(negedge clk);
      chk("out_valid", {63'd0, ov_a}, {63'd0, done});
      chk("busy", {63'd0, busy_a}, {63'd0, open});
      chk("out", 64'(out_a), 64'(e_out));
      chk("outp", 64'(outp_a), 64'(e_outp));
      chk("count", 64'(count_a), 64'(n > 127 ? 127 : n));
      chk("count_sat3", 64'(count_b), 64'(n > 7 ? 7 : n));
      chk("out_cw3", 64'(out_b), 64'(e_out));
      chk("ov_cw3", {63'd0, ov_b}, {63'd0, done});
`ifdef COMPARE_STREAM_SECOND_EN
      chk("out2", 64'(out2_a), 64'(e_out2));
      chk("outp2", 64'(outp2_a), 64'(e_outp2));
      chk("outp2_cw3", 64'(outp2_b), 64'(e_outp2));
`endif
    end
  end
  task automatic drive(input logic s, input logic v, input logic [DW-1:0] d, input logic [IW-1:0] i, input logic l);
    startsig = s; in_valid = v; in_data = d; in_idx = i; in_last = l;
    @(posedge clk);
    #1;
    startsig = 0; in_valid = 0; in_last = 0;
  endtask
  initial begin
    repeat (2) @(posedge clk);
    #1 rst = 0;
    drive(0, 1, 7, 2, 1);
    drive(0, 1, 3, 1, 0);
    @(negedge clk);
    chk("idle_out", 64'(out_a), 0);
    chk("idle_ov", {63'd0, ov_a}, 0);
    drive(1, 0, 0, 0, 0);
    drive(0, 1, 100, 0, 0);
    drive(0, 1, 40, 1, 0);
    drive(0, 1, 75, 2, 0);
    drive(0, 1, 40, 3, 1);
    @(negedge clk);
    chk("basic_ov", {63'd0, ov_a}, 1);
    chk("basic_out", 64'(out_a), 40);
    chk("basic_outp", 64'(outp_a), 1);
    chk("basic_count", 64'(count_a), 4);
    drive(1, 0, 0, 0, 0);
    drive(0, 1, 5, 0, 0);
    drive(0, 1, 9, 1, 0);
    drive(1, 1, 1, 2, 0);
    drive(0, 1, 30, 3, 0);
    drive(0, 1, 20, 4, 1);
    @(negedge clk);
    chk("restart_out", 64'(out_a), 20);
    chk("restart_outp", 64'(outp_a), 4);
    chk("restart_count", 64'(count_a), 2);
    drive(1, 0, 0, 0, 0);
    drive(0, 1, 7, 0, 1);
    @(negedge clk);
    chk("b2b_a_out", 64'(out_a), 7);
    chk("b2b_a_outp", 64'(outp_a), 0);
    drive(1, 0, 0, 0, 0);
    chk("b2b_busy", {63'd0, busy_a}, 1);
    drive(0, 1, 3, 5, 0);
    drive(0, 1, 8, 6, 1);
    @(negedge clk);
    chk("b2b_b_ov", {63'd0, ov_a}, 1);
    chk("b2b_b_out", 64'(out_a), 3);
    chk("b2b_b_outp", 64'(outp_a), 5);
    repeat (3) drive(0, 1, 1, 1, 1);
    chk("hold_out", 64'(out_a), 3);
    drive(1, 0, 0, 0, 0);
    drive(0, 1, 2, 1, 0);
    rst = 1;
    @(posedge clk);
    #1 rst = 0;
    @(negedge clk);
    chk("rst_busy", {63'd0, busy_a}, 0);
    chk("rst_ov", {63'd0, ov_a}, 0);
    chk("rst_out", 64'(out_a), 0);
    drive(1, 0, 0, 0, 0);
    for (int i = 0; i < 9; i++) drive(0, 1, ONES, 6'(i), 0);
    drive(0, 1, ONES - 1, 9, 1);
    @(negedge clk);
    chk("sat_count3", 64'(count_b), 7);
    chk("sat_count7", 64'(count_a), 10);
    chk("sat_out", 64'(out_a), 64'h3FFFE);
    chk("sat_outp", 64'(outp_a), 9);
    drive(1, 0, 0, 0, 0);
    drive(0, 1, ONES, 3, 0);
    drive(0, 1, ONES, 4, 1);
    @(negedge clk);
    chk("ones_out", 64'(out_a), 64'h3FFFF);
    chk("ones_outp", 64'(outp_a), 0);
    drive(1, 0, 0, 0, 0);
    drive(0, 1, 50, 0, 0);
    drive(0, 1, 20, 1, 0);
    drive(0, 1, 30, 2, 1);
    @(negedge clk);
    chk("sec_out", 64'(out_a), 20);
    chk("sec_outp", 64'(outp_a), 1);
`ifdef COMPARE_STREAM_SECOND_EN
    chk("sec_out2", 64'(out2_a), 30);
    chk("sec_outp2", 64'(outp2_a), 2);
`endif
    drive(1, 0, 0, 0, 0);
    drive(0, 1, 4, 3, 1);
    @(negedge clk);
    chk("one_out", 64'(out_a), 4);
    chk("one_outp", 64'(outp_a), 3);
`ifdef COMPARE_STREAM_SECOND_EN
    chk("one_out2", 64'(out2_a), 64'h3FFFF);
    chk("one_outp2", 64'(outp2_a), 0);
`endif
    repeat (3) @(posedge clk);
    #1;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
